// File: rtl/shop_wallet.sv
// shop_wallet: wallet and transaction controller sitting upstream of shop.
// Holds player credit, issues one buy_valid pulse per request, applies the shop
// result and queues reward credit that arrives while a purchase is in flight.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid, req_action        purchase request from game control; req_ready high in IDLE
//   earn_valid, earn_amount      reward credit strobe and amount
//   buy_valid, action_number,    request to shop (one-cycle pulse, latched action,
//   credit_in                    current credit)
//   purchase_success, err_*,     result flags, post-purchase credit and granted item
//   credit_out, grant_onehot     returned by shop
//   credit                       current wallet credit
//   done, status                 completion pulse and held result code
//                                (0 ok, 1 invalid, 2 out of stock, 3 no credit, 4 timeout)
//   inv_count                    per-action owned counts, 3 bits each
// Optional feature: define SHOP_WALLET_INVENTORY_EN to add inventory counters and inv_count.
module shop_wallet #(
  parameter logic [9:0] INIT_CREDIT = 10'd1000,
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  req_action,
  output logic        req_ready,
  input  logic        earn_valid,
  input  logic [9:0]  earn_amount,
  output logic        buy_valid,
  output logic [2:0]  action_number,
  output logic [9:0]  credit_in,
  input  logic        purchase_success,
  input  logic        err_invalid_action,
  input  logic        err_credit,
  input  logic        err_out_of_stock,
  input  logic [9:0]  credit_out,
  input  logic [4:0]  grant_onehot,
  output logic [9:0]  credit,
  output logic        done,
  output logic [2:0]  status
`ifdef SHOP_WALLET_INVENTORY_EN
  , output logic [14:0] inv_count
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state;
  logic [9:0] pending;
  logic [3:0] timer;
  logic [9:0] earn;
  logic [9:0] base;
  logic [2:0] result;
  logic accept, any_flag, time_up, complete;
  function automatic logic [9:0] sat(input logic [11:0] v);
    return v > 12'd1023 ? 10'd1023 : v[9:0];
  endfunction
  assign req_ready = state == IDLE;
  assign credit_in = credit;
  assign accept = req_ready && req_valid;
  assign earn = earn_valid ? earn_amount : 10'd0;
  assign any_flag = err_invalid_action | err_out_of_stock | err_credit | purchase_success;
  assign time_up = timer == 4'(TIMEOUT_CYCLES - 1);
  assign complete = state == WAIT && (any_flag || time_up);
  // errors outrank success; no flag at all means the timer expired
  assign result = err_invalid_action ? 3'd1 :
                  err_out_of_stock   ? 3'd2 :
                  err_credit         ? 3'd3 :
                  purchase_success   ? 3'd0 : 3'd4;
  assign base = result == 3'd0 ? credit_out : credit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      credit <= INIT_CREDIT;
      pending <= 10'd0;
      buy_valid <= 1'b0;
      action_number <= 3'd0;
      done <= 1'b0;
      status <= 3'd0;
      timer <= 4'd0;
    end else begin
      buy_valid <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            action_number <= req_action;
            buy_valid <= 1'b1;
            pending <= sat(12'(pending) + 12'(earn));
            state <= ISSUE;
          end else
            credit <= sat(12'(credit) + 12'(earn));
        ISSUE: begin
          timer <= 4'd0;
          pending <= sat(12'(pending) + 12'(earn));
          state <= WAIT;
        end
        default:
          if (complete) begin
            done <= 1'b1;
            status <= result;
            // same-cycle earn joins the queued reward in one clamped sum
            credit <= sat(12'(base) + 12'(pending) + 12'(earn));
            pending <= 10'd0;
            state <= IDLE;
          end else begin
            timer <= timer + 4'd1;
            pending <= sat(12'(pending) + 12'(earn));
          end
      endcase
    end
`ifdef SHOP_WALLET_INVENTORY_EN
  logic [2:0] grant_idx;
  always_comb begin
    grant_idx = 3'd0;
    for (int i = 4; i >= 0; i--) if (grant_onehot[i]) grant_idx = 3'(i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      inv_count <= 15'd0;
    else
      for (int i = 0; i < 5; i++)
        if (complete && result == 3'd0 && |grant_onehot && grant_idx == 3'(i) && inv_count[3*i +: 3] != 3'd7)
          inv_count[3*i +: 3] <= inv_count[3*i +: 3] + 3'd1;
`else
  logic unused_grant;
  assign unused_grant = ^grant_onehot;
`endif
endmodule

// File: tb/tb_shop_wallet.sv
// tb_shop_wallet: randomized self-checking bench for shop_wallet with a shop model and a wallet reference model
module tb_shop_wallet;
  localparam int TMO = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 1'b0, earn_valid = 1'b0;
  logic [2:0] req_action = 3'd0;
  logic [9:0] earn_amount = 10'd0;
  logic req_ready, buy_valid, done;
  logic [2:0] action_number, status;
  logic [9:0] credit_in, credit;
  logic f_ok, f_inv, f_cr, f_oos;
  logic [9:0] credit_out;
  logic [4:0] grant;
`ifdef SHOP_WALLET_INVENTORY_EN
  logic [14:0] inv_count;
`endif
  int checks = 0, errors = 0;
  int mode = 0;
  logic [3:0] raw_flags = 4'd0;
  logic [9:0] raw_co = 10'd0;
  logic [4:0] raw_grant = 5'd0;
  int price [5] = '{120, 200, 50, 50, 10};
  int shop_stock [5];
  int ref_credit, tot, cyc, bv_cnt, exp_st, exp_cyc;
  int ref_stock [5];
  int ref_inv [5];
  bit bv_first, ready_bad, stable_bad;

  shop_wallet #(.INIT_CREDIT(10'd1000), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_action(req_action),
    .req_ready(req_ready), .earn_valid(earn_valid), .earn_amount(earn_amount),
    .buy_valid(buy_valid), .action_number(action_number), .credit_in(credit_in),
    .purchase_success(f_ok), .err_invalid_action(f_inv), .err_credit(f_cr),
    .err_out_of_stock(f_oos), .credit_out(credit_out), .grant_onehot(grant),
    .credit(credit), .done(done), .status(status)
`ifdef SHOP_WALLET_INVENTORY_EN
    , .inv_count(inv_count)
`endif
  );

  // shop model: mode 0 real shop, 1 disconnected, 2 scripted flags, 3 random stray flags
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {f_inv, f_oos, f_cr, f_ok} <= 4'd0;
      grant <= 5'd0;
      credit_out <= 10'd0;
      for (int i = 0; i < 5; i++) shop_stock[i] <= 5;
    end else begin
      {f_inv, f_oos, f_cr, f_ok} <= mode == 3 ? 4'($urandom) : 4'd0;
      grant <= 5'd0;
      if (buy_valid && mode == 2) begin
        {f_inv, f_oos, f_cr, f_ok} <= raw_flags;
        credit_out <= raw_co;
        grant <= raw_grant;
      end else if (buy_valid && mode == 0) begin
        if (action_number > 3'd4) f_inv <= 1'b1;
        else if (shop_stock[int'(action_number)] == 0) f_oos <= 1'b1;
        else if (int'(credit_in) < price[int'(action_number)]) f_cr <= 1'b1;
        else begin
          f_ok <= 1'b1;
          credit_out <= 10'(int'(credit_in) - price[int'(action_number)]);
          grant <= 5'd1 << action_number;
          shop_stock[int'(action_number)] <= shop_stock[int'(action_number)] - 1;
        end
      end
    end

  function automatic int sat(int v);
    return v > 1023 ? 1023 : v;
  endfunction

`ifdef SHOP_WALLET_INVENTORY_EN
  function automatic logic [14:0] exp_inv();
    logic [14:0] v;
    v = '0;
    for (int i = 0; i < 5; i++) v[3*i +: 3] = 3'(ref_inv[i]);
    return v;
  endfunction
`endif

  task automatic bump_inv(input int a);
    if (a >= 0 && ref_inv[a] < 7) ref_inv[a]++;
  endtask

  // reference for a purchase against the real shop: the shop's pricing and stock rules
  task automatic model_shop(input int a);
    if (a > 4) exp_st = 1;
    else if (ref_stock[a] == 0) exp_st = 2;
    else if (ref_credit < price[a]) exp_st = 3;
    else exp_st = 0;
    if (exp_st == 0) begin
      ref_credit = sat(ref_credit - price[a] + tot);
      ref_stock[a]--;
      bump_inv(a);
    end else ref_credit = sat(ref_credit + tot);
    exp_cyc = 3;
  endtask

  // reference for scripted flags {invalid, out_of_stock, credit, success}
  task automatic model_raw(input logic [3:0] fl, input int co, input logic [4:0] g);
    int lb;
    lb = -1;
    for (int i = 4; i >= 0; i--) if (g[i]) lb = i;
    exp_st = fl[3] ? 1 : fl[2] ? 2 : fl[1] ? 3 : fl[0] ? 0 : 4;
    exp_cyc = exp_st == 4 ? TMO + 2 : 3;
    if (exp_st == 0) begin
      ref_credit = sat(co + tot);
      bump_inv(lb);
    end else ref_credit = sat(ref_credit + tot);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; earn_valid = 1'b0; mode = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ref_credit = 1000;
    for (int i = 0; i < 5; i++) begin ref_stock[i] = 5; ref_inv[i] = 0; end
  endtask

  task automatic idle_earn(input int e);
    earn_valid = e != 0; earn_amount = 10'(e);
    ref_credit = sat(ref_credit + e);
    @(posedge clk); #1;
    earn_valid = 1'b0;
  endtask

  // drives one request and follows it until done (bounded); records observations only
  task automatic txn(input logic [2:0] act, input bit rnd, input int e_at, input int e_val);
    int e;
    logic [9:0] cin_seen;
    tot = 0; bv_cnt = 0; cyc = 0; bv_first = 0; ready_bad = 0; stable_bad = 0;
    cin_seen = 10'd0;
    for (int i = 0; i < 25 && !(i > 0 && done); i++) begin
      e = i == e_at ? e_val : (rnd && $urandom_range(1) == 1) ? int'($urandom_range(400)) : 0;
      req_valid = i == 0; req_action = act;
      earn_valid = e != 0; earn_amount = 10'(e); tot += e;
      @(posedge clk); #1;
      cyc = i + 1;
      bv_cnt += int'(buy_valid);
      if (i == 0) begin
        bv_first = buy_valid;
        cin_seen = credit_in;
        if (action_number !== act) stable_bad = 1;
      end else if (!done && (action_number !== act || credit_in !== cin_seen)) stable_bad = 1;
      if (req_ready !== done) ready_bad = 1;
    end
    req_valid = 1'b0; earn_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (credit !== 10'd1000) begin errors++; $display("FAIL reset_credit got %0d exp 1000", credit); end
    checks++; if ({req_ready, buy_valid, done} !== 3'b100) begin errors++; $display("FAIL reset_ctrl got ready/buy/done=%b exp 100", {req_ready, buy_valid, done}); end
    checks++; if ({action_number, status} !== 6'd0) begin errors++; $display("FAIL reset_regs got action=%0d status=%0d exp 0 0", action_number, status); end
`ifdef SHOP_WALLET_INVENTORY_EN
    checks++; if (inv_count !== 15'd0) begin errors++; $display("FAIL reset_inv got %h exp 0", inv_count); end
`endif
  endtask

  task automatic test_kick();
    txn(3'd0, 1'b0, -1, 0);
    model_shop(0);
    checks++; if (!bv_first || bv_cnt != 1 || ready_bad || stable_bad) begin errors++; $display("FAIL kick_protocol got bv_first=%0d bv_cnt=%0d ready_bad=%0d stable_bad=%0d exp 1 1 0 0", bv_first, bv_cnt, ready_bad, stable_bad); end
    checks++; if (status !== 3'd0 || cyc != 3) begin errors++; $display("FAIL kick_status got st=%0d cyc=%0d exp st=0 cyc=3", status, cyc); end
    checks++; if (credit !== 10'd880) begin errors++; $display("FAIL kick_credit got %0d exp 880", credit); end
`ifdef SHOP_WALLET_INVENTORY_EN
    checks++; if (inv_count !== exp_inv()) begin errors++; $display("FAIL kick_inv got %h exp %h", inv_count, exp_inv()); end
`endif
  endtask

  task automatic test_invalid();
    txn(3'd6, 1'b0, -1, 0);
    model_shop(6);
    checks++; if (status !== 3'd1 || cyc != 3) begin errors++; $display("FAIL invalid_status got st=%0d cyc=%0d exp st=1 cyc=3", status, cyc); end
    checks++; if (credit !== 10'd880) begin errors++; $display("FAIL invalid_credit got %0d exp 880", credit); end
  endtask

  task automatic test_no_credit();
    mode = 2; raw_flags = 4'b0001; raw_co = 10'd50; raw_grant = 5'd0;
    txn(3'd0, 1'b0, -1, 0);
    model_raw(raw_flags, 50, raw_grant);
    checks++; if (credit !== 10'd50) begin errors++; $display("FAIL setup50_credit got %0d exp 50", credit); end
`ifdef SHOP_WALLET_INVENTORY_EN
    checks++; if (inv_count !== exp_inv()) begin errors++; $display("FAIL nogrant_inv got %h exp %h", inv_count, exp_inv()); end
`endif
    mode = 0;
    txn(3'd1, 1'b0, -1, 0);
    model_shop(1);
    checks++; if (status !== 3'd3 || credit !== 10'd50) begin errors++; $display("FAIL nocredit got st=%0d credit=%0d exp st=3 credit=50", status, credit); end
    idle_earn(1000);
    checks++; if (credit !== 10'd1023) begin errors++; $display("FAIL earn_sat got %0d exp 1023", credit); end
  endtask

  task automatic test_stock();
    do_reset();
    for (int n = 0; n < 5; n++) begin
      txn(3'd0, 1'b0, -1, 0);
      model_shop(0);
      checks++; if (status !== 3'd0) begin errors++; $display("FAIL stock_buy%0d got st=%0d exp 0", n, status); end
    end
    checks++; if (credit !== 10'd400) begin errors++; $display("FAIL stock_credit got %0d exp 400", credit); end
    txn(3'd0, 1'b0, -1, 0);
    model_shop(0);
    checks++; if (status !== 3'd2 || credit !== 10'd400) begin errors++; $display("FAIL sold_out got st=%0d credit=%0d exp st=2 credit=400", status, credit); end
`ifdef SHOP_WALLET_INVENTORY_EN
    checks++; if (inv_count[2:0] !== 3'd5) begin errors++; $display("FAIL kick_count got %0d exp 5", inv_count[2:0]); end
`endif
  endtask

  task automatic test_timeout();
    mode = 1;
    txn(3'd2, 1'b0, -1, 0);
    model_raw(4'd0, 0, 5'd0);
    checks++; if (status !== 3'd4 || cyc != TMO + 2) begin errors++; $display("FAIL timeout got st=%0d cyc=%0d exp st=4 cyc=%0d", status, cyc, TMO + 2); end
    checks++; if (credit !== 10'd400 || ready_bad || bv_cnt != 1) begin errors++; $display("FAIL timeout_credit got credit=%0d ready_bad=%0d bv_cnt=%0d exp 400 0 1", credit, ready_bad, bv_cnt); end
    mode = 0;
  endtask

  task automatic test_earn_wait();
    do_reset();
    txn(3'd0, 1'b0, 2, 30);
    model_shop(0);
    checks++; if (status !== 3'd0 || credit !== 10'd910) begin errors++; $display("FAIL earn_wait got st=%0d credit=%0d exp st=0 credit=910", status, credit); end
  endtask

  task automatic test_reset_mid();
    int dn;
    mode = 1;
    txn(3'd4, 1'b0, -1, 0);
    model_raw(4'd0, 0, 5'd0);
    idle_earn(7);
    req_valid = 1'b1; req_action = 3'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (credit !== 10'd1000 || status !== 3'd0 || action_number !== 3'd0) begin errors++; $display("FAIL midrst_regs got credit=%0d st=%0d action=%0d exp 1000 0 0", credit, status, action_number); end
    checks++; if ({req_ready, buy_valid, done} !== 3'b100) begin errors++; $display("FAIL midrst_ctrl got ready/buy/done=%b exp 100", {req_ready, buy_valid, done}); end
    @(posedge clk); #1 rst_n = 1'b1;
    mode = 0;
    ref_credit = 1000;
    for (int i = 0; i < 5; i++) begin ref_stock[i] = 5; ref_inv[i] = 0; end
    dn = 0;
    repeat (8) begin @(posedge clk); #1; dn += int'(done); end
    checks++; if (dn != 0 || credit !== 10'd1000) begin errors++; $display("FAIL midrst_after got dones=%0d credit=%0d exp 0 1000", dn, credit); end
  endtask

  task automatic test_stray();
    int dn, e;
    logic [2:0] st0;
    st0 = status; dn = 0;
    mode = 3;
    for (int i = 0; i < 20; i++) begin
      e = $urandom_range(1) == 1 ? int'($urandom_range(100)) : 0;
      earn_valid = e != 0; earn_amount = 10'(e); ref_credit = sat(ref_credit + e);
      @(posedge clk); #1;
      dn += int'(done);
    end
    earn_valid = 1'b0; mode = 0;
    @(posedge clk); #1;
    checks++; if (dn != 0 || status !== st0) begin errors++; $display("FAIL stray_done got dones=%0d st=%0d exp 0 %0d", dn, status, st0); end
    checks++; if (int'(credit) != ref_credit) begin errors++; $display("FAIL stray_credit got %0d exp %0d", credit, ref_credit); end
  endtask

  task automatic test_back_to_back();
    int a;
    mode = 0;
    for (int n = 0; n < 10; n++) begin
      a = $urandom_range(5);
      txn(3'(a), 1'b1, -1, 0);
      model_shop(a);
      checks++; if (status !== 3'(exp_st) || cyc != exp_cyc || !bv_first) begin errors++; $display("FAIL b2b%0d got st=%0d cyc=%0d bv=%0d exp st=%0d cyc=%0d bv=1", n, status, cyc, bv_first, exp_st, exp_cyc); end
      checks++; if (int'(credit) != ref_credit) begin errors++; $display("FAIL b2b%0d_credit got %0d exp %0d", n, credit, ref_credit); end
    end
  endtask

  task automatic test_random();
    int a, m, co;
    logic [3:0] fl;
    logic [4:0] g;
    for (int n = 0; n < 40; n++) begin
      m = $urandom_range(2); a = $urandom_range(7);
      fl = $urandom_range(3) == 0 ? 4'd0 : 4'($urandom);
      co = $urandom_range(1023); g = 5'($urandom);
      raw_flags = fl; raw_co = 10'(co); raw_grant = g; mode = m;
      repeat ($urandom_range(2)) idle_earn($urandom_range(1) == 1 ? int'($urandom_range(300)) : 0);
      txn(3'(a), 1'b1, -1, 0);
      if (m == 0) model_shop(a); else model_raw(m == 1 ? 4'd0 : fl, co, g);
      checks++; if (status !== 3'(exp_st) || cyc != exp_cyc) begin errors++; $display("FAIL rand%0d_status got st=%0d cyc=%0d exp st=%0d cyc=%0d", n, status, cyc, exp_st, exp_cyc); end
      checks++; if (int'(credit) != ref_credit) begin errors++; $display("FAIL rand%0d_credit got %0d exp %0d", n, credit, ref_credit); end
      checks++; if (!bv_first || bv_cnt != 1 || ready_bad || stable_bad) begin errors++; $display("FAIL rand%0d_protocol got bv_first=%0d bv_cnt=%0d ready_bad=%0d stable_bad=%0d exp 1 1 0 0", n, bv_first, bv_cnt, ready_bad, stable_bad); end
`ifdef SHOP_WALLET_INVENTORY_EN
      checks++; if (inv_count !== exp_inv()) begin errors++; $display("FAIL rand%0d_inv got %h exp %h", n, inv_count, exp_inv()); end
`endif
    end
    mode = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_kick();
    test_invalid();
    test_no_credit();
    test_stock();
    test_timeout();
    test_earn_wait();
    test_reset_mid();
    test_stray();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
